// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared defaults and read-port packing helpers for the
//                scoreboarded register file and the decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package rf_pkg;

  // Default data word width.
  localparam int c_word_w_def    = 32;
  // Default register index width (2**c_reg_idx_w_def registers).
  localparam int c_reg_idx_w_def = 5;

  // LSB position of a port's field inside a packed multi-port bus.
  function automatic int rd_lsb(input int port, input int width);
    return port * width;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
//  Module      : rf_read_port
//  Description : One combinational read port: register mux, x0 masking and
//                optional writeback bypass.
//  Config      : RF_BYPASS_EN - forward the in-flight writeback to the read.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_read_port
  import rf_pkg::*;
#(
  parameter int WORD_W    = c_word_w_def,
  parameter int REG_IDX_W = c_reg_idx_w_def
) (
  input  logic [REG_IDX_W-1:0]    rd_idx_i,
  input  logic [WORD_W-1:0]       regs_i [2**REG_IDX_W],
  input  logic [2**REG_IDX_W-1:0] busy_i,
  input  logic                    iss_en_i,
  input  logic [REG_IDX_W-1:0]    iss_reg_i,
  input  logic                    wb_en_i,
  input  logic [REG_IDX_W-1:0]    wb_reg_i,
  input  logic [WORD_W-1:0]       wb_data_i,
  output logic [WORD_W-1:0]       rd_data_o,
  output logic                    rd_busy_o
);

  logic byp_hit;
  logic byp_busy;

`ifdef RF_BYPASS_EN
  // Writeback landing this cycle is visible now; a same-cycle issue re-arms busy.
  assign byp_hit  = wb_en_i && (wb_reg_i == rd_idx_i);
  assign byp_busy = iss_en_i && (iss_reg_i == rd_idx_i);
`else
  assign byp_hit  = 1'b0;
  assign byp_busy = 1'b0;
  logic unused_bypass;
  assign unused_bypass = ^{iss_en_i, iss_reg_i, wb_en_i, wb_reg_i};
`endif

  // Select stored or forwarded value; x0 always reads as an idle zero.
  always_comb begin
    rd_data_o = regs_i[rd_idx_i];
    rd_busy_o = busy_i[rd_idx_i];
    if (byp_hit) begin
      rd_data_o = wb_data_i;
      rd_busy_o = byp_busy;
    end
    if (rd_idx_i == '0) begin
      rd_data_o = '0;
      rd_busy_o = 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_sb
//  Description : Register file with per-register busy scoreboard, NUM_RD
//                combinational read ports, one writeback and one issue port.
//  Config      : RF_BYPASS_EN - same-cycle writeback forwarding on reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import rf_pkg::*;
#(
  parameter int WORD_W    = c_word_w_def,
  parameter int REG_IDX_W = c_reg_idx_w_def,
  parameter int NUM_RD    = 2
) (
  input  logic                        clk,
  input  logic                        rf_reset,
  input  logic                        clr,
  input  logic [NUM_RD*REG_IDX_W-1:0] i_rd_idx,
  output logic [NUM_RD*WORD_W-1:0]    o_rd_data,
  output logic [NUM_RD-1:0]           o_rd_busy,
  input  logic                        i_iss_en,
  input  logic [REG_IDX_W-1:0]        i_iss_reg,
  input  logic                        i_wb_en,
  input  logic [REG_IDX_W-1:0]        i_wb_reg,
  input  logic [WORD_W-1:0]           i_wb_data,
  output logic [REG_IDX_W-1:0]        o_busy_cnt,
  output logic                        o_stall
);

  localparam int c_num_regs = 2**REG_IDX_W;

  logic [WORD_W-1:0]     regs_q [c_num_regs];
  logic [c_num_regs-1:0] busy_q;
  logic [c_num_regs-1:0] busy_d;
  logic [REG_IDX_W-1:0]  cnt_q;
  logic [REG_IDX_W-1:0]  cnt_d;
  logic                  iss_ok;
  logic                  wb_ok;

  // Traffic aimed at x0 is dropped at the source.
  assign iss_ok = i_iss_en && (i_iss_reg != '0);
  assign wb_ok  = i_wb_en && (i_wb_reg != '0);

  // Next scoreboard: clear, then retire writeback, then issue (newest producer wins).
  always_comb begin
    busy_d = clr ? '0 : busy_q;
    if (wb_ok) begin
      busy_d[i_wb_reg] = 1'b0;
    end
    if (iss_ok) begin
      busy_d[i_iss_reg] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  // Popcount of the next scoreboard; x0 is never busy so the count cannot wrap.
  always_comb begin
    cnt_d = '0;
    for (int i = 1; i < c_num_regs; i++) begin
      cnt_d = cnt_d + REG_IDX_W'(busy_d[i]);
    end
  end

  // Register storage: writeback lands at the edge, reset zeroes everything.
  always_ff @(posedge clk or negedge rf_reset) begin
    if (!rf_reset) begin
      for (int i = 0; i < c_num_regs; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_ok) begin
      regs_q[i_wb_reg] <= i_wb_data;
    end
  end

  // Scoreboard and busy count state.
  always_ff @(posedge clk or negedge rf_reset) begin
    if (!rf_reset) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd_port
    rf_read_port #(
      .WORD_W    (WORD_W),
      .REG_IDX_W (REG_IDX_W)
    ) u_rd_port (
      .rd_idx_i  (i_rd_idx[rd_lsb(k, REG_IDX_W) +: REG_IDX_W]),
      .regs_i    (regs_q),
      .busy_i    (busy_q),
      .iss_en_i  (i_iss_en),
      .iss_reg_i (i_iss_reg),
      .wb_en_i   (i_wb_en),
      .wb_reg_i  (i_wb_reg),
      .wb_data_i (i_wb_data),
      .rd_data_o (o_rd_data[rd_lsb(k, WORD_W) +: WORD_W]),
      .rd_busy_o (o_rd_busy[k])
    );
  end

  assign o_busy_cnt = cnt_q;
  assign o_stall    = |o_rd_busy;

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_sb
//  Description : Self-checking bench for regfile_sb: directed scenarios with
//                literal expectations plus randomized traffic checked every
//                cycle against a behavioural register/scoreboard model.
//  Config      : RF_BYPASS_EN - expectations follow the same macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_sb;

  localparam int W    = 32;
  localparam int IW   = 5;
  localparam int NR   = 2;
  localparam int NREG = 2**IW;

  logic             clk;
  logic             rf_reset;
  logic             clr;
  logic [NR*IW-1:0] i_rd_idx;
  logic [NR*W-1:0]  o_rd_data;
  logic [NR-1:0]    o_rd_busy;
  logic             i_iss_en;
  logic [IW-1:0]    i_iss_reg;
  logic             i_wb_en;
  logic [IW-1:0]    i_wb_reg;
  logic [W-1:0]     i_wb_data;
  logic [IW-1:0]    o_busy_cnt;
  logic             o_stall;

  regfile_sb #(.WORD_W(W), .REG_IDX_W(IW), .NUM_RD(NR)) dut (
    .clk        (clk),
    .rf_reset   (rf_reset),
    .clr        (clr),
    .i_rd_idx   (i_rd_idx),
    .o_rd_data  (o_rd_data),
    .o_rd_busy  (o_rd_busy),
    .i_iss_en   (i_iss_en),
    .i_iss_reg  (i_iss_reg),
    .i_wb_en    (i_wb_en),
    .i_wb_reg   (i_wb_reg),
    .i_wb_data  (i_wb_data),
    .o_busy_cnt (o_busy_cnt),
    .o_stall    (o_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [W-1:0] m_regs [NREG];
  bit           m_busy [NREG];

  // The model state after each edge, from the rules: data lands, issue beats
  // writeback, clear drops everything older than this cycle's issue.
  always @(posedge clk or negedge rf_reset) begin
    if (!rf_reset) begin
      for (int r = 0; r < NREG; r++) begin
        m_regs[r] <= '0;
        m_busy[r] <= 1'b0;
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (i_wb_en && (int'(i_wb_reg) == r)) m_regs[r] <= i_wb_data;
        m_busy[r] <= (i_iss_en && (int'(i_iss_reg) == r)) ? 1'b1 :
                     (i_wb_en  && (int'(i_wb_reg)  == r)) ? 1'b0 :
                     clr ? 1'b0 : m_busy[r];
      end
    end
  end

  function automatic void exp_read(input logic [IW-1:0] idx, output logic [W-1:0] d,
                                   output logic b);
    d = m_regs[idx];
    b = m_busy[idx];
`ifdef RF_BYPASS_EN
    if (i_wb_en && (i_wb_reg == idx)) begin
      d = i_wb_data;
      b = i_iss_en && (i_iss_reg == idx);
    end
`endif
    if (idx == '0) begin
      d = '0;
      b = 1'b0;
    end
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < NREG; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  // Every-cycle comparison, mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (chk_en && rf_reset) begin
      logic [W-1:0] d;
      logic         b;
      logic         st;
      st = 1'b0;
      for (int k = 0; k < NR; k++) begin
        exp_read(i_rd_idx[k*IW +: IW], d, b);
        chk("mdl_data", o_rd_data[k*W +: W], d);
        chk("mdl_busy", W'(o_rd_busy[k]), W'(b));
        st = st | b;
      end
      chk("mdl_stall", W'(o_stall), W'(st));
      chk("mdl_cnt", W'(o_busy_cnt), W'(exp_cnt()));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input int a, input int b);
    i_rd_idx[0 +: IW]  = IW'(a);
    i_rd_idx[IW +: IW] = IW'(b);
  endtask

  task automatic idle();
    i_iss_en = 1'b0;
    i_wb_en  = 1'b0;
    clr      = 1'b0;
  endtask

  function automatic logic [W-1:0] rdd(input int k);
    return o_rd_data[k*W +: W];
  endfunction

  initial begin
    rf_reset  = 1'b0;
    clr       = 1'b0;
    i_rd_idx  = '0;
    i_iss_en  = 1'b0;
    i_iss_reg = '0;
    i_wb_en   = 1'b0;
    i_wb_reg  = '0;
    i_wb_data = '0;
    #22 rf_reset = 1'b1;
    chk_en = 1'b1;

    // Reset state on every index.
    for (int r = 0; r < NREG; r++) begin
      cyc();
      set_rd(r, NREG - 1 - r);
      #1;
      chk("rst_data0", rdd(0), 32'h0);
      chk("rst_data1", rdd(1), 32'h0);
      chk("rst_busy", W'(o_rd_busy), 32'h0);
      chk("rst_cnt", W'(o_busy_cnt), 32'h0);
      chk("rst_stall", W'(o_stall), 32'h0);
    end

    // Issue x5 then write it back.
    cyc();
    i_iss_en = 1'b1; i_iss_reg = 5; set_rd(5, 0);
    cyc();
    idle(); #1;
    chk("iss5_busy", W'(o_rd_busy[0]), 32'h1);
    chk("iss5_stall", W'(o_stall), 32'h1);
    chk("iss5_cnt", W'(o_busy_cnt), 32'h1);
    i_wb_en = 1'b1; i_wb_reg = 5; i_wb_data = 32'hDEADBEEF;
    cyc();
    idle(); #1;
    chk("wb5_data", rdd(0), 32'hDEADBEEF);
    chk("wb5_busy", W'(o_rd_busy[0]), 32'h0);
    chk("wb5_cnt", W'(o_busy_cnt), 32'h0);
    chk("wb5_stall", W'(o_stall), 32'h0);

    // Same-cycle visibility of a writeback to x7 on port 1.
    set_rd(0, 7);
    i_wb_en = 1'b1; i_wb_reg = 7; i_wb_data = 32'h12345678;
    #1;
`ifdef RF_BYPASS_EN
    chk("byp7_data", rdd(1), 32'h12345678);
`else
    chk("nobyp7_data", rdd(1), 32'h0);
`endif
    chk("byp7_busy", W'(o_rd_busy[1]), 32'h0);
    cyc();
    idle(); #1;
    chk("wb7_data", rdd(1), 32'h12345678);

    // Issue and writeback on busy x3 in the same cycle.
    i_iss_en = 1'b1; i_iss_reg = 3;
    cyc();
    idle(); #1;
    chk("iss3_cnt", W'(o_busy_cnt), 32'h1);
    i_iss_en = 1'b1; i_iss_reg = 3;
    i_wb_en = 1'b1; i_wb_reg = 3; i_wb_data = 32'h55;
    set_rd(3, 3);
    cyc();
    idle(); #1;
    chk("x3_data0", rdd(0), 32'h55);
    chk("x3_data1", rdd(1), 32'h55);
    chk("x3_busy", W'(o_rd_busy), 32'h3);
    chk("x3_cnt", W'(o_busy_cnt), 32'h1);
    i_wb_en = 1'b1; i_wb_reg = 3; i_wb_data = 32'h66;
    cyc();
    idle(); #1;
    chk("x3_ret_cnt", W'(o_busy_cnt), 32'h0);

    // x0 is immune to issue and writeback.
    i_iss_en = 1'b1; i_iss_reg = 0;
    i_wb_en = 1'b1; i_wb_reg = 0; i_wb_data = 32'hFFFFFFFF;
    set_rd(0, 0);
    cyc();
    idle(); #1;
    chk("x0_data", rdd(0), 32'h0);
    chk("x0_busy", W'(o_rd_busy[0]), 32'h0);
    chk("x0_cnt", W'(o_busy_cnt), 32'h0);

    // Fill the scoreboard, then clear with a concurrent issue of x9.
    for (int r = 1; r < NREG; r++) begin
      i_iss_en = 1'b1; i_iss_reg = IW'(r);
      cyc();
    end
    idle(); #1;
    chk("full_cnt", W'(o_busy_cnt), 32'd31);
    set_rd(31, 1); #1;
    chk("full_busy", W'(o_rd_busy), 32'h3);
    chk("full_stall", W'(o_stall), 32'h1);
    clr = 1'b1; i_iss_en = 1'b1; i_iss_reg = 9;
    cyc();
    idle(); #1;
    chk("clr_cnt", W'(o_busy_cnt), 32'h1);
    for (int r = 0; r < NREG; r++) begin
      cyc();
      set_rd(r, r);
      #1;
      chk("clr_busy", W'(o_rd_busy[0]), (r == 9) ? 32'h1 : 32'h0);
    end

    // Asynchronous reset between edges with four registers busy.
    clr = 1'b1; i_wb_en = 1'b1; i_wb_reg = 20; i_wb_data = 32'hA5A5A5A5;
    cyc();
    idle();
    for (int r = 10; r < 14; r++) begin
      i_iss_en = 1'b1; i_iss_reg = IW'(r);
      cyc();
    end
    idle(); #1;
    chk("pre_rst_cnt", W'(o_busy_cnt), 32'h4);
    set_rd(10, 20); #1;
    chk("pre_rst_data", rdd(1), 32'hA5A5A5A5);
    rf_reset = 1'b0;
    #1;
    chk("arst_cnt", W'(o_busy_cnt), 32'h0);
    chk("arst_busy", W'(o_rd_busy), 32'h0);
    chk("arst_stall", W'(o_stall), 32'h0);
    chk("arst_data1", rdd(1), 32'h0);
    i_iss_en = 1'b1; i_iss_reg = 14;
    i_wb_en = 1'b1; i_wb_reg = 21; i_wb_data = 32'hCAFE;
    cyc();
    idle();
    #3 rf_reset = 1'b1;
    cyc();
    set_rd(14, 21); #1;
    chk("post_rst_busy", W'(o_rd_busy[0]), 32'h0);
    chk("post_rst_data", rdd(1), 32'h0);
    chk("post_rst_cnt", W'(o_busy_cnt), 32'h0);
    i_iss_en = 1'b1; i_iss_reg = 15;
    cyc();
    idle(); set_rd(15, 0); #1;
    chk("post_rst_iss", W'(o_rd_busy[0]), 32'h1);
    chk("post_rst_iss_cnt", W'(o_busy_cnt), 32'h1);

    // Randomized traffic, checked by the per-cycle model comparison.
    repeat (3000) begin
      cyc();
      i_iss_en  = 1'($urandom_range(0, 1));
      i_iss_reg = IW'($urandom_range(0, NREG - 1));
      i_wb_en   = 1'($urandom_range(0, 1));
      i_wb_reg  = IW'($urandom_range(0, NREG - 1));
      i_wb_data = $urandom;
      clr       = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 3) == 0) i_iss_reg = i_wb_reg;
      for (int k = 0; k < NR; k++) begin
        i_rd_idx[k*IW +: IW] = ($urandom_range(0, 2) == 0) ? i_wb_reg
                                                            : IW'($urandom_range(0, NREG - 1));
      end
    end
    cyc();
    idle();
    cyc();
    @(negedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
